ysyx_23060184_axi_sram: RTL and testbench

AXI4-lite-style memory responder: the slave end of the SoC memory channel that the LSU/IFU-side master drives.
- Holds a word-addressed SRAM array.
- Accepts one transaction at a time, read or write.
- Inserts a programmable access latency, then returns the response with OKAY/SLVERR/DECERR status.
- Used as the simulation-side backing memory and as a stand-in for SoC memory in unit benches.

---
 rtl/ysyx_23060184_axi_sram_if.sv | 40 ++++
 rtl/ysyx_23060184_axi_sram.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_23060184_axi_sram.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060184_axi_sram_if.sv
// AXI4-lite-style memory channel between an LSU/IFU master and the SRAM responder.
interface ysyx_23060184_axi_sram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [DATA_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] awaddr;
  logic [ID_WIDTH-1:0]   awid;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic [ID_WIDTH-1:0]   bid;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awid, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready,
           bresp, bid, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awid, awvalid,
           wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready,
           bresp, bid, bvalid
  );
endinterface

// File: rtl/ysyx_23060184_axi_sram.sv
// Single-outstanding AXI4-lite SRAM responder with a fixed access latency.
// Reads win over writes in IDLE; the array itself is never reset.
module ysyx_23060184_axi_sram #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ID_WIDTH   = 4,
  parameter int unsigned          DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] BASE      = DATA_WIDTH'(32'h8000_0000),
  parameter int unsigned          LATENCY    = 2
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060184_axi_sram_if.slave bus
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NBYTES = 4;
  localparam logic [CNT_W-1:0]      LAT  = CNT_W'(LATENCY);
  localparam logic [DATA_WIDTH:0]   SPAN = (DATA_WIDTH+1)'(DEPTH) << 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_R_WAIT = 3'd1;
  localparam logic [2:0] S_R_RESP = 3'd2;
  localparam logic [2:0] S_W_DATA = 3'd3;
  localparam logic [2:0] S_W_WAIT = 3'd4;
  localparam logic [2:0] S_W_RESP = 3'd5;

  // Wide subtraction so BASE + 4*DEPTH cannot wrap the address space.
  function automatic logic in_range(input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return (a >= BASE) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] off;
    off = a - BASE;
    return IDX_W'(off >> 2);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0]            state,   state_d;
  logic [CNT_W-1:0]      cnt,     cnt_d;
  logic [DATA_WIDTH-1:0] addr_q,  addr_d;
  logic [ID_WIDTH-1:0]   id_q,    id_d;
  logic [1:0]            wresp_q, wresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   bid_q,   bid_d;
  logic                  bvalid_q, bvalid_d;
  logic                  mem_we_c;
  logic                  hit_c;
  logic [IDX_W-1:0]      idx_c;

  assign hit_c = in_range(addr_q);
  assign idx_c = word_index(addr_q);

  assign bus.arready = (state == S_IDLE);
  assign bus.awready = (state == S_IDLE) && !bus.arvalid;
  assign bus.wready  = (state == S_W_DATA);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;
  assign bus.bvalid  = bvalid_q;

  // Next-state, latency counter and response staging.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    addr_d   = addr_q;
    id_d     = id_q;
    wresp_d  = wresp_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    bvalid_d = bvalid_q;
    mem_we_c = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.arvalid) begin
          addr_d  = bus.araddr;
          cnt_d   = LAT;
          state_d = (LATENCY == 0) ? S_R_RESP : S_R_WAIT;
        end else if (bus.awvalid) begin
          addr_d  = bus.awaddr;
          id_d    = bus.awid;
          state_d = S_W_DATA;
        end
      end

      S_R_WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = S_R_RESP;
      end

      // First cycle in R_RESP captures the response; it then holds until accepted.
      S_R_RESP: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = hit_c ? mem[idx_c] : '0;
          rresp_d  = hit_c ? RESP_OKAY : RESP_DECERR;
        end else if (bus.rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_W_DATA: begin
        if (bus.wvalid) begin
          mem_we_c = hit_c && bus.wlast;
          if (!hit_c)          wresp_d = RESP_DECERR;
          else if (!bus.wlast) wresp_d = RESP_SLVERR;
          else                 wresp_d = RESP_OKAY;
          cnt_d   = LAT;
          state_d = (LATENCY == 0) ? S_W_RESP : S_W_WAIT;
        end
      end

      S_W_WAIT: begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = S_W_RESP;
      end

      S_W_RESP: begin
        if (!bvalid_q) begin
          bvalid_d = 1'b1;
          bid_d    = id_q;
          bresp_d  = wresp_q;
        end else if (bus.bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      wresp_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rvalid_q <= 1'b0;
      bresp_q  <= '0;
      bid_q    <= '0;
      bvalid_q <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      wresp_q  <= wresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
      bvalid_q <= bvalid_d;
    end
  end

  // Byte-masked array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int k = 0; k < int'(NBYTES); k++) begin
        if (bus.wstrb[k]) mem[idx_c][8*k +: 8] <= bus.wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_axi_sram.sv
// Bench for the AXI SRAM responder: directed cases plus random traffic against a word/byte model.
module tb_ysyx_23060184_axi_sram;

  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 4;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060184_axi_sram_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();
  ysyx_23060184_axi_sram_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus0 ();

  ysyx_23060184_axi_sram #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH),
                           .BASE(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  ysyx_23060184_axi_sram #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH),
                           .BASE(BASE), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference memory: word contents plus which bytes have ever been written.
  logic [31:0] mdl [DEPTH];
  logic [3:0]  kb  [DEPTH];

  // Transaction phase as the master sees it: 0 idle, 1 read busy, 2 awaiting W, 3 write busy.
  int ph = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic stop_timeout(input string what);
    errors++;
    $display("FAIL %s: got timeout expected handshake", what);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "bounded wait expired");
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(4 * DEPTH)));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [31:0] rnd_addr();
    case ($urandom % 8)
      0:       return BASE - 32'd4;
      1:       return BASE + 32'(4 * DEPTH);
      2:       return BASE + 32'(4 * DEPTH - 4) + 32'($urandom % 4);
      default: return BASE + 32'(4 * ($urandom % 16)) + 32'($urandom % 4);
    endcase
  endfunction

  // Compare process: ready signals follow the phase, held responses stay frozen.
  bit          p_r, p_b;
  logic [31:0] p_rdata;
  logic [1:0]  p_rresp, p_bresp;
  logic [3:0]  p_bid;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      p_r = 1'b0;
      p_b = 1'b0;
    end else begin
      chk("arready", 32'(bus.arready), 32'(ph == 0));
      chk("awready", 32'(bus.awready), 32'(ph == 0 && !bus.arvalid));
      chk("wready",  32'(bus.wready),  32'(ph == 2));
      if (ph == 0) begin
        chk("idle_rvalid", 32'(bus.rvalid), 32'd0);
        chk("idle_bvalid", 32'(bus.bvalid), 32'd0);
      end
      if (p_r) begin
        chk("hold_rvalid", 32'(bus.rvalid), 32'd1);
        chk("hold_rdata",  bus.rdata, p_rdata);
        chk("hold_rresp",  32'(bus.rresp), 32'(p_rresp));
      end
      if (p_b) begin
        chk("hold_bvalid", 32'(bus.bvalid), 32'd1);
        chk("hold_bresp",  32'(bus.bresp), 32'(p_bresp));
        chk("hold_bid",    32'(bus.bid), 32'(p_bid));
      end
      p_r = bus.rvalid && !bus.rready;
      p_b = bus.bvalid && !bus.bready;
      p_rdata = bus.rdata;
      p_rresp = bus.rresp;
      p_bresp = bus.bresp;
      p_bid   = bus.bid;
    end
  end

  // Called just after a rising edge; returns after the R handshake edge.
  task automatic do_read(input logic [31:0] a, input int bp,
                         output logic [31:0] d, output logic [1:0] r);
    bit          hit;
    logic [31:0] ed, m;
    int          n;
    hit = in_rng(a);
    ed  = hit ? mdl[widx(a)] : 32'd0;
    m   = hit ? bmask(kb[widx(a)]) : 32'hFFFF_FFFF;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.arready) break;
      @(posedge clk); #1;
      if (++n > 50) stop_timeout("ar_handshake");
    end
    @(posedge clk);
    ph = 1;
    #1 bus.arvalid = 1'b0;
    bus.araddr = $urandom;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.rvalid) break;
      @(posedge clk);
      if (++n > 300) stop_timeout("rvalid");
    end
    chk("r_latency", 32'(n), 32'(LAT + 1));
    chk("rresp", 32'(bus.rresp), hit ? 32'd0 : 32'd3);
    chk("rdata", bus.rdata & m, ed & m);
    d = bus.rdata;
    r = bus.rresp;
    @(posedge clk);
    repeat (bp) @(posedge clk);
    #1 bus.rready = 1'b1;
    @(posedge clk);
    ph = 0;
    #1 bus.rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [31:0] dat,
                          input logic [3:0] s, input bit last, input int wgap, input int bp,
                          input bit early, output logic [1:0] br);
    bit         hit;
    logic [1:0] er;
    int         n;
    hit = in_rng(a);
    er  = !hit ? 2'b11 : (!last ? 2'b10 : 2'b00);
    if (early) begin
      // Data offered before the address phase must be ignored.
      bus.wdata  = ~dat;
      bus.wstrb  = 4'hF;
      bus.wlast  = 1'b1;
      bus.wvalid = 1'b1;
      @(posedge clk); #1;
    end
    bus.awaddr  = a;
    bus.awid    = id;
    bus.awvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.awready) break;
      @(posedge clk); #1;
      if (++n > 50) stop_timeout("aw_handshake");
    end
    @(posedge clk);
    ph = 2;
    #1 bus.awvalid = 1'b0;
    bus.awaddr = $urandom;
    bus.awid   = 4'($urandom);
    bus.wvalid = 1'b0;
    if (wgap > 0) begin
      repeat (wgap) @(posedge clk);
      #1;
    end
    bus.wdata  = dat;
    bus.wstrb  = s;
    bus.wlast  = last;
    bus.wvalid = 1'b1;
    @(posedge clk);
    ph = 3;
    if (hit && last)
      for (int k = 0; k < 4; k++)
        if (s[k]) begin
          mdl[widx(a)][8*k +: 8] = dat[8*k +: 8];
          kb[widx(a)][k] = 1'b1;
        end
    #1 bus.wvalid = 1'b0;
    bus.wdata = $urandom;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.bvalid) break;
      @(posedge clk);
      if (++n > 300) stop_timeout("bvalid");
    end
    chk("b_latency", 32'(n), 32'(LAT + 1));
    chk("bresp", 32'(bus.bresp), 32'(er));
    chk("bid", 32'(bus.bid), 32'(id));
    br = bus.bresp;
    @(posedge clk);
    repeat (bp) @(posedge clk);
    #1 bus.bready = 1'b1;
    @(posedge clk);
    ph = 0;
    #1 bus.bready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mdl[i] = '0;
      kb[i]  = '0;
    end
    {bus.araddr, bus.arvalid, bus.rready, bus.awaddr, bus.awid, bus.awvalid} = '0;
    {bus.wdata, bus.wstrb, bus.wvalid, bus.bready} = '0;
    bus.wlast = 1'b1;
    {bus0.araddr, bus0.arvalid, bus0.rready, bus0.awaddr, bus0.awid, bus0.awvalid} = '0;
    {bus0.wdata, bus0.wstrb, bus0.wvalid, bus0.bready} = '0;
    bus0.wlast = 1'b1;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rvalid",  32'(bus.rvalid), 32'd0);
    chk("rst_bvalid",  32'(bus.bvalid), 32'd0);
    chk("rst_rdata",   bus.rdata, 32'd0);
    chk("rst_rresp",   32'(bus.rresp), 32'd0);
    chk("rst_bresp",   32'(bus.bresp), 32'd0);
    chk("rst_bid",     32'(bus.bid), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;

    // Basic write then read-back.
    do_write(32'h8000_0010, 4'd3, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 0, 1'b0, r);
    chk("t1_bresp", 32'(r), 32'd0);
    do_read(32'h8000_0010, 0, d, r);
    chk("t1_rdata", d, 32'hDEAD_BEEF);
    chk("t1_rresp", 32'(r), 32'd0);

    // Byte strobes.
    do_write(32'h8000_0010, 4'd7, 32'h1122_3344, 4'b0101, 1'b1, 1, 0, 1'b1, r);
    do_read(32'h8000_0010, 0, d, r);
    chk("strb_rdata", d, 32'hDE22_BE44);

    // Out-of-range read and write.
    do_read(32'h7FFF_FFFC, 0, d, r);
    chk("oor_rresp", 32'(r), 32'd3);
    chk("oor_rdata", d, 32'd0);
    do_write(32'h8000_0000, 4'd1, 32'hA5A5_0001, 4'hF, 1'b1, 0, 0, 1'b0, r);
    do_write(32'h8000_1000, 4'd2, 32'h5A5A_FFFF, 4'hF, 1'b1, 0, 2, 1'b0, r);
    chk("oor_bresp", 32'(r), 32'd3);
    do_read(32'h8000_0000, 0, d, r);
    chk("oor_unchanged", d, 32'hA5A5_0001);

    // Long read backpressure.
    do_read(32'h8000_0010, 5, d, r);

    // Simultaneous AR and AW: read wins, then a wlast=0 write is refused.
    do_write(32'h8000_0020, 4'd4, 32'hCAFE_F00D, 4'hF, 1'b1, 0, 0, 1'b0, r);
    bus.awaddr  = 32'h8000_0020;
    bus.awid    = 4'd9;
    bus.awvalid = 1'b1;
    bus.araddr  = 32'h8000_0010;
    bus.arvalid = 1'b1;
    #1;
    chk("sim_arready", 32'(bus.arready), 32'd1);
    chk("sim_awready", 32'(bus.awready), 32'd0);
    do_read(32'h8000_0010, 0, d, r);
    chk("sim_rdata", d, 32'hDE22_BE44);
    do_write(32'h8000_0020, 4'd9, 32'h0000_0000, 4'hF, 1'b0, 0, 0, 1'b0, r);
    chk("wlast0_bresp", 32'(r), 32'd2);
    do_read(32'h8000_0020, 0, d, r);
    chk("wlast0_unchanged", d, 32'hCAFE_F00D);

    // Reset while the read waits out its latency.
    bus.araddr  = 32'h8000_0010;
    bus.arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    ph = 1;
    #1 bus.arvalid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rvalid",  32'(bus.rvalid), 32'd0);
    chk("mid_rst_arready", 32'(bus.arready), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    ph = 0;
    do_read(32'h8000_0010, 1, d, r);
    chk("post_rst_rdata", d, 32'hDE22_BE44);

    // Randomised traffic against the model.
    for (int t = 0; t < 80; t++) begin
      if ($urandom % 2 == 0)
        do_read(rnd_addr(), int'($urandom % 4), d, r);
      else
        do_write(rnd_addr(), 4'($urandom), $urandom, 4'($urandom), ($urandom % 8) != 0,
                 int'($urandom % 3), int'($urandom % 4), ($urandom % 3) == 0, r);
    end

    // Zero-latency instance: response one cycle after the handshake edge.
    @(posedge clk); #1;
    bus0.awaddr  = 32'h8000_0004;
    bus0.awid    = 4'd5;
    bus0.awvalid = 1'b1;
    @(negedge clk);
    chk("l0_awready", 32'(bus0.awready), 32'd1);
    @(posedge clk); #1;
    bus0.awvalid = 1'b0;
    bus0.wdata   = 32'h1234_5678;
    bus0.wstrb   = 4'hF;
    bus0.wlast   = 1'b1;
    bus0.wvalid  = 1'b1;
    @(negedge clk);
    chk("l0_wready", 32'(bus0.wready), 32'd1);
    @(posedge clk); #1 bus0.wvalid = 1'b0;
    @(negedge clk);
    chk("l0_bvalid_early", 32'(bus0.bvalid), 32'd0);
    @(negedge clk);
    chk("l0_bvalid", 32'(bus0.bvalid), 32'd1);
    chk("l0_bid",    32'(bus0.bid), 32'd5);
    chk("l0_bresp",  32'(bus0.bresp), 32'd0);
    @(posedge clk); #1 bus0.bready = 1'b1;
    @(posedge clk); #1 bus0.bready = 1'b0;
    bus0.araddr  = 32'h8000_0004;
    bus0.arvalid = 1'b1;
    @(negedge clk);
    chk("l0_bvalid_drop", 32'(bus0.bvalid), 32'd0);
    chk("l0_arready", 32'(bus0.arready), 32'd1);
    @(posedge clk); #1 bus0.arvalid = 1'b0;
    @(negedge clk);
    chk("l0_rvalid_early", 32'(bus0.rvalid), 32'd0);
    @(negedge clk);
    chk("l0_rvalid", 32'(bus0.rvalid), 32'd1);
    chk("l0_rdata",  bus0.rdata, 32'h1234_5678);
    chk("l0_rresp",  32'(bus0.rresp), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("l0_hold_rvalid", 32'(bus0.rvalid), 32'd1);
      chk("l0_hold_rdata",  bus0.rdata, 32'h1234_5678);
    end
    @(posedge clk); #1 bus0.rready = 1'b1;
    @(posedge clk); #1 bus0.rready = 1'b0;
    @(negedge clk);
    chk("l0_rvalid_drop", 32'(bus0.rvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
